// File: rtl/gb_timer_pkg.sv
// Shared types and helpers for the multi-channel DMG-style timer array.
// Optional cascade feature: GB_TIMER_CASCADE_EN (see gb_timer_array.sv).
package gb_timer_pkg;

  // TAC register contents, bit 4 down to bit 0.
  typedef struct packed {
    logic       casc;
    logic       oneshot;
    logic       en;
    logic [1:0] sel;
  } tac_t;

  // Per-channel state: IDLE/COUNT follow TAC.en, OVF is the cycle TIMA reads 00,
  // RELOAD is the cycle TIMA holds TMA and the IRQ pulse is raised.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_OVF    = 2'd2,
    ST_RELOAD = 2'd3
  } ch_state_e;

  // Offsets from BASE_ADDR; channel i adds 3*i to the TIMA/TMA/TAC offsets.
  localparam logic [15:0] OFS_DIV  = 16'd0;
  localparam logic [15:0] OFS_TIMA = 16'd1;
  localparam logic [15:0] OFS_TMA  = 16'd2;
  localparam logic [15:0] OFS_TAC  = 16'd3;

  // System-counter bit watched by a channel for a given TAC.sel.
  function automatic logic tap_sel(input logic [1:0] sel, input logic [15:0] sys);
    logic [3:0] idx;
    case (sel)
      2'b00:   idx = 4'd9;
      2'b01:   idx = 4'd3;
      2'b10:   idx = 4'd5;
      default: idx = 4'd7;
    endcase
    return sys[idx];
  endfunction

endpackage

// File: rtl/gb_timer_channel.sv
// One timer channel: TIMA/TMA/TAC registers, falling-edge tick detector and the
// overflow -> reload sequence. state_o exposes the channel FSM for debug and is
// used by the top to build the IRQ pulse and the cascade tick.
module gb_timer_channel
  import gb_timer_pkg::*;
#(
  parameter bit CASC_OK = 1'b0  // channel may take its tick from the previous channel
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sys_i,
  input  logic        wr_tima_i,
  input  logic        wr_tma_i,
  input  logic        wr_tac_i,
  input  logic [7:0]  wdata_i,
  input  logic        casc_tick_i,
  output logic [7:0]  tima_o,
  output logic [7:0]  tma_o,
  output logic [4:0]  tac_o,
  output logic [1:0]  state_o
);

  logic [7:0] tima_q, tima_d;
  logic [7:0] tma_q, tma_d;
  tac_t       tac_q, tac_d;
  logic       edge_q;
  ch_state_e  state_q, state_d;
  logic       sig;
  logic       tick;

  // Tick source: the gated tap falls (this also catches the DIV-clear and
  // TAC-change glitches), or in cascade mode the previous channel's reload.
  always_comb begin
    sig  = tac_q.en & tap_sel(tac_q.sel, sys_i);
    tick = edge_q & ~sig;
    if (CASC_OK && tac_q.casc) begin
      tick = tac_q.en & casc_tick_i;
    end
  end

  // Register writes, counting and the OVF/RELOAD sequence.
  always_comb begin
    tma_d   = wr_tma_i ? wdata_i : tma_q;
    tac_d   = tac_q;
    tima_d  = tima_q;
    state_d = state_q;
    if (wr_tac_i) begin
      tac_d = tac_t'(wdata_i[4:0]);
      if (!CASC_OK) begin
        tac_d.casc = 1'b0;
      end
    end
    case (state_q)
      ST_OVF: begin
        if (wr_tima_i) begin
          // CPU write in the overflow cycle cancels reload and IRQ.
          tima_d  = wdata_i;
          state_d = tac_d.en ? ST_COUNT : ST_IDLE;
        end else begin
          // Reload takes TMA including a TMA write in this same cycle.
          tima_d  = tma_d;
          state_d = ST_RELOAD;
          if (tac_d.oneshot) begin
            tac_d.en = 1'b0;
          end
        end
      end
      ST_RELOAD: begin
        // TIMA keeps tracking TMA; a TIMA write here is dropped.
        tima_d  = tma_d;
        state_d = tac_d.en ? ST_COUNT : ST_IDLE;
      end
      default: begin
        state_d = tac_d.en ? ST_COUNT : ST_IDLE;
        if (wr_tima_i) begin
          tima_d = wdata_i;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Channel state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= '0;
      edge_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      edge_q  <= sig;
      state_q <= state_d;
    end
  end

  assign tima_o  = tima_q;
  assign tma_o   = tma_q;
  assign tac_o   = tac_q;
  assign state_o = state_q;

endmodule

// File: rtl/gb_timer_array.sv
// Timer array: shared 16-bit system counter (DIV) feeding NUM_CH TIMA/TMA/TAC
// channels on the CPU I/O bus. Channel i registers sit at BASE_ADDR+1+3i..+3+3i.
// Define GB_TIMER_CASCADE_EN to let channel i>=1 count reloads of channel i-1.
module gb_timer_array
  import gb_timer_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        data_i,
  input  logic [15:0]       addr,
  input  logic              wren,
  output logic [7:0]        data_o,
  output logic [NUM_CH-1:0] irq_timer
);

  logic [15:0]       sys_q, sys_d;
  logic [15:0]       ofs;
  logic [7:0]        tima [NUM_CH];
  logic [7:0]        tma  [NUM_CH];
  logic [4:0]        tac  [NUM_CH];
  logic [1:0]        st   [NUM_CH];
  logic [NUM_CH-1:0] reload;

  assign ofs = addr - BASE_ADDR;

  // Free-running system counter; any DIV write restarts it from zero.
  always_comb begin
    sys_d = sys_q + 16'd1;
    if (wren && (ofs == OFS_DIV)) begin
      sys_d = 16'h0000;
    end
  end

  // System counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_q <= 16'h0000;
    end else begin
      sys_q <= sys_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [15:0] CH_OFS = 16'(3 * i);
    logic casc_tick;
`ifdef GB_TIMER_CASCADE_EN
    localparam bit CASC_OK = (i > 0);
    if (i > 0) begin : g_casc
      assign casc_tick = reload[i-1];
    end else begin : g_head
      assign casc_tick = 1'b0;
    end
`else
    localparam bit CASC_OK = 1'b0;
    assign casc_tick = 1'b0;
`endif

    gb_timer_channel #(
      .CASC_OK(CASC_OK)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .sys_i      (sys_q),
      .wr_tima_i  (wren && (ofs == OFS_TIMA + CH_OFS)),
      .wr_tma_i   (wren && (ofs == OFS_TMA + CH_OFS)),
      .wr_tac_i   (wren && (ofs == OFS_TAC + CH_OFS)),
      .wdata_i    (data_i),
      .casc_tick_i(casc_tick),
      .tima_o     (tima[i]),
      .tma_o      (tma[i]),
      .tac_o      (tac[i]),
      .state_o    (st[i])
    );

    // The reload cycle is the IRQ cycle and the cascade trigger.
    assign reload[i] = (st[i] == ST_RELOAD);
  end

  assign irq_timer = reload;

  // Combinational read mux; anything not decoded reads as FF.
  always_comb begin
    data_o = 8'hFF;
    if (ofs == OFS_DIV) begin
      data_o = sys_q[15:8];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ofs == OFS_TIMA + 16'(3 * i)) data_o = tima[i];
      if (ofs == OFS_TMA + 16'(3 * i))  data_o = tma[i];
      if (ofs == OFS_TAC + 16'(3 * i))  data_o = {3'b111, tac[i]};
    end
  end

endmodule

// File: tb/tb_gb_timer_array.sv
// Bench for gb_timer_array: directed scenarios plus randomized bus traffic,
// checked every cycle against a cycle-level behavioural model of the timers.
module tb_gb_timer_array;

  localparam int          NUM_CH = 2;
  localparam logic [15:0] BASE   = 16'hFF04;
`ifdef GB_TIMER_CASCADE_EN
  localparam bit CASC = 1'b1;
`else
  localparam bit CASC = 1'b0;
`endif
  localparam logic [15:0] A_DIV  = BASE;
  localparam logic [15:0] A_TIMA0 = BASE + 16'd1;
  localparam logic [15:0] A_TMA0  = BASE + 16'd2;
  localparam logic [15:0] A_TAC0  = BASE + 16'd3;
  localparam logic [15:0] A_TIMA1 = BASE + 16'd4;
  localparam logic [15:0] A_TMA1  = BASE + 16'd5;
  localparam logic [15:0] A_TAC1  = BASE + 16'd6;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        data_i = 8'h00;
  logic [15:0]       addr = 16'h0000;
  logic              wren = 1'b0;
  logic [7:0]        data_o;
  logic [NUM_CH-1:0] irq_timer;

  always #5 clk = ~clk;

  gb_timer_array #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data_i   (data_i),
    .addr     (addr),
    .wren     (wren),
    .data_o   (data_o),
    .irq_timer(irq_timer)
  );

  int total = 0;
  int bad = 0;
  logic [NUM_CH-1:0] exp_q[$];  // expected irq_timer, one entry per clock

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_sys;
  logic [7:0]  m_tima [NUM_CH];
  logic [7:0]  m_tma  [NUM_CH];
  logic [4:0]  m_tac  [NUM_CH];   // {casc, oneshot, en, sel}
  logic        m_prev [NUM_CH];   // gated tap value last clock
  int          m_phase[NUM_CH];   // 0 normal, 1 TIMA just wrapped, 2 reloading
  int          taps[4] = '{9, 3, 5, 7};

  task automatic model_reset();
    m_sys = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tima[i] = 8'h00; m_tma[i] = 8'h00; m_tac[i] = 5'h00;
      m_prev[i] = 1'b0;  m_phase[i] = 0;
    end
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off == 0) return m_sys[15:8];
    if (off >= 1 && off <= 3 * NUM_CH) begin
      case ((off - 1) % 3)
        0:       return m_tima[(off - 1) / 3];
        1:       return m_tma[(off - 1) / 3];
        default: return {3'b111, m_tac[(off - 1) / 3]};
      endcase
    end
    return 8'hFF;
  endfunction

  task automatic model_step();
    int off;
    int ph_old[NUM_CH];
    bit tick[NUM_CH];
    logic sig;
    logic [7:0] tma_n;
    logic [4:0] tac_n;
    bit wt;
    logic [NUM_CH-1:0] irq;
    off = int'(addr) - int'(BASE);
    for (int i = 0; i < NUM_CH; i++) ph_old[i] = m_phase[i];
    for (int i = 0; i < NUM_CH; i++) begin
      sig = m_tac[i][2] & m_sys[taps[m_tac[i][1:0]]];
      if (CASC && i > 0 && m_tac[i][4]) tick[i] = m_tac[i][2] && (ph_old[i-1] == 2);
      else tick[i] = m_prev[i] && !sig;
      m_prev[i] = sig;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      wt    = wren && (off == 1 + 3 * i);
      tma_n = (wren && off == 2 + 3 * i) ? data_i : m_tma[i];
      tac_n = m_tac[i];
      if (wren && off == 3 + 3 * i) begin
        tac_n = data_i[4:0];
        if (!(CASC && i > 0)) tac_n[4] = 1'b0;
      end
      if (ph_old[i] == 1) begin
        if (wt) begin m_tima[i] = data_i; m_phase[i] = 0; end
        else begin
          m_tima[i] = tma_n; m_phase[i] = 2;
          if (tac_n[3]) tac_n[2] = 1'b0;
        end
      end else if (ph_old[i] == 2) begin
        m_tima[i] = tma_n; m_phase[i] = 0;
      end else if (wt) begin
        m_tima[i] = data_i;
      end else if (tick[i]) begin
        if (m_tima[i] == 8'hFF) begin m_tima[i] = 8'h00; m_phase[i] = 1; end
        else m_tima[i] = m_tima[i] + 8'd1;
      end
      m_tma[i] = tma_n;
      m_tac[i] = tac_n;
    end
    m_sys = (wren && off == 0) ? 16'h0000 : m_sys + 16'd1;
    for (int i = 0; i < NUM_CH; i++) irq[i] = (m_phase[i] == 2);
    exp_q.push_back(irq);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- driver tasks ----------------
  // One bus cycle: drive at the falling edge, then compare read data and IRQ.
  task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d);
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    addr = a; wren = w; data_i = d;
    #1;
    check("irq_q_depth", 16'(exp_q.size()), 16'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("irq", 16'(irq_timer), 16'(e));
    check("rdata", 16'(data_o), 16'(model_read(a)));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    wren = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("rst_irq", 16'(irq_timer), 16'd0);
    addr = A_DIV;  #1 check("rst_div", 16'(data_o), 16'h00);
    addr = A_TAC0; #1 check("rst_tac0", 16'(data_o), 16'hE0);
    addr = A_TAC1; #1 check("rst_tac1", 16'(data_o), 16'hE0);
    addr = A_TIMA0; #1 check("rst_tima0", 16'(data_o), 16'h00);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int pulses;
    logic [15:0] a;
    logic [7:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();

    // Overflow, reload to TMA with IRQ, then the 32-clock period.
    repeat (37) cyc(BASE + 16'd10, 1'b0, 8'h00);
    pulse_reset();
    cyc(A_TAC0, 1'b1, 8'h05);
    cyc(A_TMA0, 1'b1, 8'hFE);
    cyc(A_TIMA0, 1'b1, 8'hFF);
    n = 0;
    do begin cyc(A_TIMA0, 1'b0, 8'h00); n++; end while (data_o != 8'h00 && n < 40);
    check("ovf_zero", 16'(data_o), 16'h00);
    cyc(A_TIMA0, 1'b0, 8'h00);
    check("reload_val", 16'(data_o), 16'hFE);
    check("reload_irq", 16'(irq_timer[0]), 16'd1);
    n = 0;
    do begin cyc(A_TIMA0, 1'b0, 8'h00); n++; end while (!irq_timer[0] && n < 64);
    check("irq_period", 16'(n), 16'd32);

    // TIMA write during the overflow cycle cancels reload and IRQ.
    pulse_reset();
    cyc(A_TAC0, 1'b1, 8'h05);
    cyc(A_TMA0, 1'b1, 8'hFE);
    cyc(A_TIMA0, 1'b1, 8'hFF);
    n = 0;
    do begin cyc(A_TIMA0, 1'b0, 8'h00); n++; end while (data_o != 8'h00 && n < 40);
    check("ovf_zero2", 16'(data_o), 16'h00);
    wren = 1'b1; data_i = 8'h10;
    cyc(A_TIMA0, 1'b0, 8'h00);
    check("ovf_write", 16'(data_o), 16'h10);
    check("ovf_no_irq", 16'(irq_timer[0]), 16'd0);
    repeat (4) cyc(A_TIMA0, 1'b0, 8'h00);

    // DIV clear while the selected bit is high gives exactly one tick.
    pulse_reset();
    cyc(A_TAC0, 1'b1, 8'h05);
    n = 0;
    while (!(m_sys[3] && m_sys[2:0] < 3'd6) && n < 40) begin cyc(A_TIMA0, 1'b0, 8'h00); n++; end
    check("div_wait", 16'(n < 40), 16'd1);
    cyc(A_DIV, 1'b1, 8'h5A);
    repeat (3) cyc(A_TIMA0, 1'b0, 8'h00);
    check("div_glitch", 16'(data_o), 16'h01);

    // One-shot on channel 1.
    pulse_reset();
    cyc(A_TMA1, 1'b1, 8'h33);
    cyc(A_TAC1, 1'b1, 8'h0D);
    cyc(A_TIMA1, 1'b1, 8'hFF);
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      cyc(A_TIMA1, 1'b0, 8'h00);
      if (irq_timer[1]) pulses++;
    end
    check("oneshot_pulses", 16'(pulses), 16'd1);
    cyc(A_TAC1, 1'b0, 8'h00);
    check("oneshot_tac", 16'(data_o), 16'hE9);
    cyc(A_TIMA1, 1'b0, 8'h00);
    check("oneshot_tima", 16'(data_o), 16'h33);

    // Cascade: channel 1 counts channel 0 reloads (or stays put without it).
    pulse_reset();
    cyc(A_TMA0, 1'b1, 8'hFF);
    cyc(A_TIMA0, 1'b1, 8'hFF);
    cyc(A_TAC0, 1'b1, 8'h05);
    cyc(A_TAC1, 1'b1, 8'h14);
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      cyc(A_TIMA0, 1'b0, 8'h00);
      if (irq_timer[0]) pulses++;
    end
    check("casc_src_pulses", 16'(pulses >= 3), 16'd1);
    cyc(A_TAC1, 1'b0, 8'h00);
    check("casc_tac1", 16'(data_o), CASC ? 16'hF4 : 16'hE4);
    cyc(A_TIMA1, 1'b0, 8'h00);
    check("casc_tima1", 16'(data_o), CASC ? 16'(pulses) : 16'h00);

    // Randomized bus traffic, including unmapped addresses and resets.
    pulse_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else begin
        a = BASE - 16'd1 + 16'($urandom_range(0, 3 * NUM_CH + 2));
        d = 8'($urandom);
        if ((a == A_TIMA0 || a == A_TIMA1) && $urandom_range(0, 1) == 1)
          d = 8'($urandom_range(252, 255));
        if (a == A_TAC0 || a == A_TAC1) d[1:0] = ($urandom_range(0, 2) == 0) ? d[1:0] : 2'b01;
        if (a == A_DIV && $urandom_range(0, 7) != 0) cyc(a, 1'b0, d);
        else cyc(a, $urandom_range(0, 3) == 0, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
